// File: rtl/vector_draw_arbiter.sv
// vector_draw_arbiter
//   Shares one vector sprite-draw engine among N_REQ object controllers
//   (enemies, rockets, base). A round-robin pick is made in IDLE, the
//   winner's position and sprite address are latched, a one-cycle
//   draw_start is issued and the grant is held until draw_done.
//
// Handshake: req_valid is a level request; it is only looked at in IDLE.
//   draw_start is a one-cycle command to the engine; the engine answers
//   with a one-cycle draw_done at any later time (ignored in START).
//
// Optional build macro ARB_WATCHDOG_EN: adds a WAIT_DONE watchdog that
//   abandons a draw after TIMEOUT cycles without draw_done and pulses
//   timeout_err. Without it timeout_err is constant 0.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid[N]     per-requester draw request
//   req_x/req_y      packed coordinates, requester i at [i*OUT_WIDTH +: OUT_WIDTH]
//   req_adr          packed sprite start addresses, same packing
//   draw_done        engine finished pulse
//   draw_start       engine start pulse
//   draw_x/y/adr     latched data of the granted requester
//   grant            one-hot, START through the draw_done cycle
//   busy             high outside IDLE
//   timeout_err      watchdog pulse
module vector_draw_arbiter #(
  parameter int N_REQ        = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*OUT_WIDTH-1:0]      req_x,
  input  logic [N_REQ*OUT_WIDTH-1:0]      req_y,
  input  logic [N_REQ*ADDRESSWIDTH-1:0]   req_adr,
  input  logic                            draw_done,
  output logic                            draw_start,
  output logic [OUT_WIDTH-1:0]            draw_x,
  output logic [OUT_WIDTH-1:0]            draw_y,
  output logic [ADDRESSWIDTH-1:0]         draw_adr,
  output logic [N_REQ-1:0]                grant,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("vector_draw_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [IW-1:0]   next_ptr;
  logic            wd_expire;
  logic [N_REQ-1:0] one_hot_base;

  // Round-robin search starting at rr_ptr, wrapping explicitly so that
  // non-power-of-2 N_REQ never selects an out-of-range index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = int'(rr_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!pick_found && req_valid[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  assign next_ptr = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // draw_done in the expiry cycle wins: no error in that case.
  assign wd_expire = (state_q == WAIT_DONE) && !draw_done &&
                     (wd_cnt == CW'(TIMEOUT - 1));

  // Counter is held at zero outside WAIT_DONE, so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT_DONE) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= wd_expire;
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_found) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (draw_done || wd_expire) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      draw_x   <= '0;
      draw_y   <= '0;
      draw_adr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_found) begin
        idx      <= pick_idx;
        draw_x   <= req_x[int'(pick_idx)*OUT_WIDTH +: OUT_WIDTH];
        draw_y   <= req_y[int'(pick_idx)*OUT_WIDTH +: OUT_WIDTH];
        draw_adr <= req_adr[int'(pick_idx)*ADDRESSWIDTH +: ADDRESSWIDTH];
      end
      if (state_q == WAIT_DONE && (draw_done || wd_expire)) rr_ptr <= next_ptr;
    end
  end

  // Outputs decode directly from the state register, so they are glitch
  // free and return to zero in the same cycle the FSM reaches IDLE.
  assign one_hot_base = N_REQ'(1);
  assign draw_start   = (state_q == START);
  assign busy         = (state_q != IDLE);
  assign grant        = busy ? (one_hot_base << idx) : '0;

endmodule

// File: tb/tb_vector_draw_arbiter.sv
module tb_vector_draw_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x, req_y;
  logic [N*AW-1:0] req_adr;
  logic           draw_done;
  logic           draw_start;
  logic [W-1:0]   draw_x, draw_y;
  logic [AW-1:0]  draw_adr;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  vector_draw_arbiter #(.N_REQ(N), .OUT_WIDTH(W), .ADDRESSWIDTH(AW), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_adr(req_adr), .draw_done(draw_done), .draw_start(draw_start),
    .draw_x(draw_x), .draw_y(draw_y), .draw_adr(draw_adr), .grant(grant),
    .busy(busy), .timeout_err(timeout_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks: all inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [AW-1:0] a);
    req_x[i*W +: W]    = x;
    req_y[i*W +: W]    = y;
    req_adr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; draw_done = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, W'(8'd11 * (i + 1)), W'(8'd3 * (i + 1)), AW'(i + 1));
    tick(); tick();
    n_cmp++; if (draw_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", draw_start); end
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({draw_x, draw_y, draw_adr} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {draw_x, draw_y, draw_adr}); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    req_valid = '0; rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    set_req(2, 8'd40, 8'd200, 8'd5);
    req_valid = 4'b0100;
    tick();
    n_cmp++; if (draw_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", draw_start); end
    n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
    n_cmp++; if ({draw_x, draw_y, draw_adr} !== {8'd40, 8'd200, 8'd5}) begin n_fail++; $display("FAIL single_data: got %0d/%0d/%0d want 40/200/5", draw_x, draw_y, draw_adr); end
    req_valid = '0;
    tick();
    n_cmp++; if (draw_start !== 1'b0 || grant !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait: got start=%b grant=%b busy=%b want 0/0100/1", draw_start, grant, busy); end
    for (int c = 0; c < 8; c++) tick();
    n_cmp++; if (grant !== 4'b0100 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL single_hold: got grant=%b terr=%b want 0100/0", grant, timeout_err); end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant=%b busy=%b want 0000/0", grant, busy); end
    n_cmp++; if (draw_x !== 8'd40) begin n_fail++; $display("FAIL single_xhold: got %0d want 40", draw_x); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_g;
    int n;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) set_req(i, W'(10 * i + 1), W'(20 * i + 2), AW'(30 * i + 3));
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      n = 0;
      tick();
      while (!draw_start && n < 10) begin tick(); n++; end
      n_cmp++; if (draw_start !== 1'b1) begin n_fail++; $display("FAIL fair_start_timeout: got no draw_start want pulse"); end
      n_cmp++; if (grant !== exp_g) begin n_fail++; $display("FAIL fair_grant: got %b want %b", grant, exp_g); end
      for (int i = 0; i < N; i++)
        if (exp_g[i]) begin
          n_cmp++; if (draw_x !== W'(10 * i + 1) || draw_adr !== AW'(30 * i + 3)) begin n_fail++; $display("FAIL fair_data: got x=%0d adr=%0d want %0d/%0d", draw_x, draw_adr, 10 * i + 1, 30 * i + 3); end
        end
      tick(); tick();
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_mid_draw_change();
    // rr pointer is at 1 after the fairness run ended on requester 0
    set_req(1, 8'd77, 8'd88, 8'd9);
    req_valid = 4'b0010;
    tick();
    n_cmp++; if (grant !== 4'b0010 || draw_start !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got %b/%b want 0010/1", grant, draw_start); end
    tick();
    req_x[1*W +: W] = 8'd99;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (draw_x !== 8'd77 || grant !== 4'b0010) begin n_fail++; $display("FAIL mid_hold: got x=%0d grant=%b want 77/0010", draw_x, grant); end
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    n_cmp++; if (grant !== 4'b0000 || draw_x !== 8'd77) begin n_fail++; $display("FAIL mid_release: got grant=%b x=%0d want 0000/77", grant, draw_x); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    tick(); tick();
    n_cmp++; if (grant !== 4'b1000 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_wait: got grant=%b busy=%b want 1000/1", grant, busy); end
    req_valid = '0;
    rst = 1'b1; req_valid = 4'b1010;
    tick();
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0 || draw_start !== 1'b0) begin n_fail++; $display("FAIL rmid_reset: got grant=%b busy=%b start=%b want 0000/0/0", grant, busy, draw_start); end
    rst = 1'b0;
    tick();
    n_cmp++; if (grant !== 4'b0010 || draw_start !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: got %b/%b want 0010/1", grant, draw_start); end
    n_cmp++; if (draw_x !== 8'd99) begin n_fail++; $display("FAIL rmid_data: got %0d want 99", draw_x); end
    // lone requester back to back: one IDLE cycle then re-granted
    req_valid = 4'b0010;
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    n_cmp++; if (busy !== 1'b0 || draw_start !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b start=%b want 0/0", busy, draw_start); end
    tick();
    n_cmp++; if (grant !== 4'b0010 || draw_start !== 1'b1) begin n_fail++; $display("FAIL b2b_regrant: got %b/%b want 0010/1", grant, draw_start); end
    req_valid = '0;
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0011;
    tick();
    n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wd_first: got %b want 0001", grant); end
    tick();
    n = 0;
    while (timeout_err !== 1'b1 && n < 1100) begin tick(); n++; end
    n_cmp++; if (n !== 1024) begin n_fail++; $display("FAIL wd_latency: got %0d want 1024", n); end
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL wd_drop: got %b want 0000", grant); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0 || grant !== 4'b0010 || draw_start !== 1'b1) begin n_fail++; $display("FAIL wd_next: got terr=%b grant=%b start=%b want 0/0010/1", timeout_err, grant, draw_start); end
    req_valid = '0;
    draw_done = 1'b1; tick(); tick(); draw_done = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_adr = '0; draw_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_mid_draw_change();
    test_reset_mid();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
